// File: rtl/ro_meter_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency meter.
// Contents:
//   state_e         measurement FSM states
//   *Default        default parameter values used by ro_freq_meter / ro_edge_sync
package ro_meter_pkg;

  localparam int unsigned WinWDefault       = 16;
  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned SettleCycDefault  = 64;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StHold
  } state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchroniser plus rising-edge detector for the divided oscillator clock.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   async_i  divided oscillator clock, asynchronous to clk
//   edge_o   one-cycle pulse per synchronised rising edge
module ro_edge_sync
  import ro_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits a settle
// interval, counts rising edges of its divided clock over a programmable
// window of clk cycles, and returns the count through a valid/ready handshake.
// Optional build macro: RO_FREQ_MINMAX_EN adds running min/max statistics.
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start_i, window_i measurement request and window length (IDLE only)
//   ro_div_i          divided oscillator clock (asynchronous)
//   ro_start_o        oscillator enable (SETTLE and MEASURE)
//   busy_o            high outside IDLE
//   res_valid_o       result held in HOLD until res_ready_i
//   count_o           rising edges counted in the window (saturating)
//   overflow_o        count saturated during the last measurement
//   stats_clr_i       (RO_FREQ_MINMAX_EN) restore min/max to reset values
//   min_o, max_o      (RO_FREQ_MINMAX_EN) smallest/largest result seen
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned WIN_W       = WinWDefault,
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SETTLE_CYC  = SettleCycDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             ro_div_i,
  output logic             ro_start_o,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] count_o,
`ifdef RO_FREQ_MINMAX_EN
  input  logic             stats_clr_i,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
`endif
  output logic             overflow_o
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             edge_pulse;

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ro_div_i),
    .edge_o (edge_pulse)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (window_i != '0)) begin
          state_d  = StSettle;
          settle_d = SettleLoad;
          win_d    = window_i;
          count_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StMeasure;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StMeasure: begin
        if (edge_pulse) begin
          // Saturate rather than wrap; overflow flags the lost edge.
          if (&count_q) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        win_d = win_q - 1'b1;
        if (win_q == WIN_W'(1)) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      win_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ro_start_o  = (state_q == StSettle) || (state_q == StMeasure);
  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = (state_q == StHold);
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;

`ifdef RO_FREQ_MINMAX_EN
  logic             enter_hold;
  logic [CNT_W-1:0] min_q, max_q;

  assign enter_hold = (state_q == StMeasure) && (state_d == StHold);

  // count_d is the final count, including an edge in the last window cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr_i) begin
      min_q <= '1;
      max_q <= '0;
    end else if (enter_hold) begin
      if (count_d < min_q) min_q <= count_d;
      if (count_d > max_q) max_q <= count_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window = '0;
  logic        ro_div;
  logic        ro_start;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  count;
  logic        overflow;
`ifdef RO_FREQ_MINMAX_EN
  logic        stats_clr = 1'b0;
  logic [7:0]  min_v;
  logic [7:0]  max_v;
`endif

  // Oscillator model: free-running square wave or a directly forced level.
  logic gen_div = 1'b0;
  int   div_half = 0;
  int   ph = 0;
  logic div_force_en = 1'b0;
  logic div_force = 1'b0;
  assign ro_div = div_force_en ? div_force : gen_div;

  int cyc = 0;
  int t0 = 0;
  int n_checks = 0;
  int n_fail = 0;

  ro_freq_meter #(
    .WIN_W      (16),
    .CNT_W      (8),
    .SETTLE_CYC (64),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .window_i   (window),
    .ro_div_i   (ro_div),
    .ro_start_o (ro_start),
    .busy_o     (busy),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .count_o    (count),
`ifdef RO_FREQ_MINMAX_EN
    .stats_clr_i(stats_clr),
    .min_o      (min_v),
    .max_o      (max_v),
`endif
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #3;
    if (div_half != 0) begin
      ph = ph + 1;
      if (ph >= div_half) begin
        ph = 0;
        gen_div = ~gen_div;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [15:0] w);
    @(negedge clk);
    start  = 1'b1;
    window = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_valid(input string name, output int lat);
    bit found = 0;
    lat = 0;
    for (int k = 0; k < 20000 && !found; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        found = 1;
        lat = cyc - t0 + 1;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: res_valid_o never rose within 20000 cycles", name);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ro_start, busy, res_valid, overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {ro_start, busy, res_valid, overflow});
    end
    n_checks++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_count();
    int lat;
    div_half = 5;
    repeat (50) @(posedge clk);
    do_start(16'd1000);
    wait_valid("basic", lat);
    n_checks++;
    if (lat != 1065) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 1065", lat);
    end
    n_checks++;
    if (count !== 8'd100) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 100", count);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_overflow: got %b expected 0", overflow);
    end
    accept();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got busy=%b valid=%b expected 0 0", busy, res_valid);
    end
  endtask

  task automatic test_settle_exclusion();
    int lat;
    int bad = 0;
    div_force    = 1'b0;
    div_force_en = 1'b1;
    repeat (5) @(posedge clk);
    do_start(16'd20);
    // Toggle only early in SETTLE, ending low; window spans k = 65..84.
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      if (k <= 40 && (k % 2) == 0) div_force = ~div_force;
      if (ro_start !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL settle_ro_start: got %0d low cycles expected 0", bad);
    end
    wait_valid("settle", lat);
    n_checks++;
    if (lat != 85) begin
      n_fail++;
      $display("FAIL settle_latency: got %0d expected 85", lat);
    end
    n_checks++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL settle_count: got %0d expected 0", count);
    end
    n_checks++;
    if (ro_start !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_ro_start_hold: got %b expected 0", ro_start);
    end
    accept();
  endtask

  task automatic test_window_one();
    int lat;
    div_force    = 1'b0;
    div_force_en = 1'b1;
    repeat (5) @(posedge clk);
    do_start(16'd1);
    // Rising input after edge 62 reaches the pulse in the single MEASURE cycle.
    repeat (62) @(posedge clk);
    #3;
    div_force = 1'b1;
    wait_valid("win1", lat);
    n_checks++;
    if (lat != 66) begin
      n_fail++;
      $display("FAIL win1_latency: got %0d expected 66", lat);
    end
    n_checks++;
    if (count !== 8'd1) begin
      n_fail++;
      $display("FAIL win1_count: got %0d expected 1", count);
    end
    accept();
    div_force = 1'b0;
  endtask

  task automatic test_saturation();
    int lat;
    div_force_en = 1'b0;
    div_half = 2;
    repeat (20) @(posedge clk);
    do_start(16'd4000);
    wait_valid("sat", lat);
    n_checks++;
    if (lat != 4065) begin
      n_fail++;
      $display("FAIL sat_latency: got %0d expected 4065", lat);
    end
    n_checks++;
    if (count !== 8'd255 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_result: got count=%0d ovf=%b expected 255 1", count, overflow);
    end
    accept();
    @(negedge clk);
    n_checks++;
    if (count !== 8'd255 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_idle_hold: got count=%0d ovf=%b expected 255 1", count, overflow);
    end
    div_half = 20;
    repeat (50) @(posedge clk);
    do_start(16'd400);
    @(negedge clk);
    n_checks++;
    if (count !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got count=%0d ovf=%b expected 0 0", count, overflow);
    end
    wait_valid("sat2", lat);
    n_checks++;
    if (count !== 8'd10 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat2_result: got count=%0d ovf=%b expected 10 0", count, overflow);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    div_half = 5;
    repeat (30) @(posedge clk);
    do_start(16'd50);
    wait_valid("bp", lat);
    n_checks++;
    if (count !== 8'd5) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 5", count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || busy !== 1'b1 || count !== 8'd5) bad++;
      if (i == 5) begin
        start  = 1'b1;
        window = 16'd10;
      end
      if (i == 6) start = 1'b0;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad);
    end
    accept();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0 || ro_start !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_idle_after: got %0d non-idle cycles expected 0", bad);
    end
    n_checks++;
    if (count !== 8'd5) begin
      n_fail++;
      $display("FAIL bp_count_kept: got %0d expected 5", count);
    end
  endtask

  task automatic test_window_zero();
    int bad = 0;
    do_start(16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || ro_start !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL win0_ignored: got %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    div_half = 5;
    do_start(16'd200);
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ro_start !== 1'b1 || count === 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got ro_start=%b count=%0d expected 1 nonzero", ro_start, count);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ro_start, busy, res_valid, overflow} !== 4'b0000 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got flags=%b count=%0d expected 0000 0",
               {ro_start, busy, res_valid, overflow}, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_result: got %0d active cycles expected 0", bad);
    end
  endtask

`ifdef RO_FREQ_MINMAX_EN
  task automatic test_minmax();
    int lat;
    div_half = 5;
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    n_checks++;
    if (min_v !== 8'd255 || max_v !== 8'd0) begin
      n_fail++;
      $display("FAIL mm_clear0: got min=%0d max=%0d expected 255 0", min_v, max_v);
    end
    do_start(16'd1000);
    wait_valid("mm1", lat);
    accept();
    do_start(16'd800);
    wait_valid("mm2", lat);
    accept();
    do_start(16'd1200);
    wait_valid("mm3", lat);
    accept();
    @(negedge clk);
    n_checks++;
    if (min_v !== 8'd80 || max_v !== 8'd120) begin
      n_fail++;
      $display("FAIL mm_stats: got min=%0d max=%0d expected 80 120", min_v, max_v);
    end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    n_checks++;
    if (min_v !== 8'd255 || max_v !== 8'd0) begin
      n_fail++;
      $display("FAIL mm_clear: got min=%0d max=%0d expected 255 0", min_v, max_v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_settle_exclusion();
    test_window_one();
    test_saturation();
    test_backpressure();
    test_window_zero();
    test_reset_mid();
`ifdef RO_FREQ_MINMAX_EN
    test_minmax();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
